gelato_reg_scoreboard: RTL and testbench

Parametrised per-warp destination-register scoreboard between decode/issue and the warp scheduler. It tracks in-flight destination registers for every warp and allocates them through a valid/ready handshake, replacing the previous fatal-on-full behaviour. Entries are released by multiple write-back ports. It gives the issue stage combinational RAW/WAW hazard results for the candidate instruction.

---
 rtl/gelato_types_pkg.sv | 19 +
 rtl/gelato_scoreboard_bank.sv | 85 ++++++++
 rtl/gelato_reg_scoreboard.sv | 93 +++++++++
 tb/tb_gelato_reg_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types_pkg.sv
// rtl/gelato_types_pkg.sv - shared scoreboard types and default sizing
package gelato_types;

   localparam int SB_WARP_NUM = 4;
   localparam int SB_SLOT_NUM = 8;
   localparam int SB_REG_W    = 5;
   localparam int SB_SRC_NUM  = 3;
   localparam int SB_WB_NUM   = 2;
   localparam int SB_WARP_W   = $clog2(SB_WARP_NUM);

   typedef logic [SB_REG_W-1:0]  sb_reg_t;
   typedef logic [SB_WARP_W-1:0] warp_idx_t;

   typedef struct packed {
      logic    valid;
      sb_reg_t idx;
   } sb_entry_t;

endpackage

// File: rtl/gelato_scoreboard_bank.sv
// rtl/gelato_scoreboard_bank.sv - one warp's dirty-register slots with match, count and free-slot logic
module gelato_scoreboard_bank
   import gelato_types::*;
#(
   parameter int SLOT_NUM = SB_SLOT_NUM,
   parameter int SRC_NUM  = SB_SRC_NUM,
   parameter int WB_NUM   = SB_WB_NUM,
   parameter int CNT_W    = $clog2(SLOT_NUM + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alloc_we,
   input  sb_reg_t                   alloc_reg,
   input  logic [WB_NUM-1:0]         wb_en,
   input  sb_reg_t [WB_NUM-1:0]      wb_reg,
   input  sb_reg_t [SRC_NUM-1:0]     chk_rs,
   input  sb_reg_t                   chk_rd,
   output logic                      alloc_dup,
   output logic [WB_NUM-1:0]         wb_miss,
   output logic                      hazard,
   output logic                      full,
   output logic [CNT_W-1:0]          cnt
);

   sb_entry_t [SLOT_NUM-1:0] entry;
   logic [SLOT_NUM-1:0]      free_oh;
   logic [SLOT_NUM-1:0]      clr_mask;
   logic [SLOT_NUM-1:0]      wb_hit [WB_NUM];

   // Register 0 means "no register" and never matches a slot.
   function automatic logic [SLOT_NUM-1:0] match(input sb_entry_t [SLOT_NUM-1:0] e,
                                                 input sb_reg_t r);
      logic [SLOT_NUM-1:0] m;
      for (int s = 0; s < SLOT_NUM; s++)
         m[s] = e[s].valid && (e[s].idx == r) && (r != '0);
      return m;
   endfunction

   always_comb begin
      alloc_dup = |match(entry, alloc_reg);
      hazard    = |match(entry, chk_rd);
      for (int i = 0; i < SRC_NUM; i++)
         hazard = hazard | (|match(entry, chk_rs[i]));

      clr_mask = '0;
      for (int p = 0; p < WB_NUM; p++) begin
         wb_hit[p]  = match(entry, wb_reg[p]);
         wb_miss[p] = ~|wb_hit[p];
         if (wb_en[p])
            clr_mask = clr_mask | wb_hit[p];
      end

      cnt  = '0;
      full = 1'b1;
      for (int s = 0; s < SLOT_NUM; s++) begin
         cnt  = cnt + CNT_W'(entry[s].valid);
         full = full & entry[s].valid;
      end

      // Scan high to low so the lowest free slot wins.
      free_oh = '0;
      for (int s = SLOT_NUM - 1; s >= 0; s--) begin
         if (!entry[s].valid) begin
            free_oh    = '0;
            free_oh[s] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry <= '0;
      end else begin
         for (int s = 0; s < SLOT_NUM; s++) begin
            if (alloc_we && free_oh[s]) begin
               entry[s].valid <= 1'b1;
               entry[s].idx   <= alloc_reg;
            end else if (clr_mask[s]) begin
               entry[s].valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/gelato_reg_scoreboard.sv
// rtl/gelato_reg_scoreboard.sv - per-warp destination-register scoreboard with alloc handshake and hazard check
module gelato_reg_scoreboard
   import gelato_types::*;
#(
   parameter int WARP_NUM = SB_WARP_NUM,
   parameter int SLOT_NUM = SB_SLOT_NUM,
   parameter int REG_W    = SB_REG_W,
   parameter int SRC_NUM  = SB_SRC_NUM,
   parameter int WB_NUM   = SB_WB_NUM,
   parameter int WARP_W   = $clog2(WARP_NUM),
   parameter int CNT_W    = $clog2(SLOT_NUM + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rdy,
   input  logic                               alloc_valid,
   output logic                               alloc_ready,
   input  logic [WARP_W-1:0]                  alloc_warp,
   input  logic [REG_W-1:0]                   alloc_reg,
   input  logic [WB_NUM-1:0]                  wb_valid,
   input  logic [WB_NUM-1:0][WARP_W-1:0]      wb_warp,
   input  logic [WB_NUM-1:0][REG_W-1:0]       wb_reg,
   input  logic [WARP_W-1:0]                  chk_warp,
   input  logic [SRC_NUM-1:0][REG_W-1:0]      chk_rs,
   input  logic [REG_W-1:0]                   chk_rd,
   output logic                               hazard,
   output logic [WARP_NUM-1:0]                warp_full,
   output logic [WARP_NUM-1:0][CNT_W-1:0]     warp_cnt,
   output logic                               err
);

   logic [WARP_NUM-1:0]             bank_dup;
   logic [WARP_NUM-1:0]             bank_haz;
   logic [WARP_NUM-1:0]             bank_full;
   logic [WARP_NUM-1:0]             bank_we;
   logic [WARP_NUM-1:0][WB_NUM-1:0] bank_wb_en;
   logic [WARP_NUM-1:0][WB_NUM-1:0] bank_miss;
   logic [WB_NUM-1:0]               wb_act;
   logic                            dup;
   logic                            accept;
   logic                            err_set;

   // Ready depends only on registered state; a same-cycle release cannot open a slot.
   assign dup         = bank_dup[alloc_warp];
   assign alloc_ready = rdy & ~bank_full[alloc_warp] & ~dup;
   assign accept      = alloc_valid & alloc_ready & (alloc_reg != '0);
   assign hazard      = bank_haz[chk_warp];
   assign warp_full   = bank_full;

   always_comb begin
      err_set = rdy & alloc_valid & dup;
      for (int p = 0; p < WB_NUM; p++) begin
         wb_act[p] = rdy & wb_valid[p] & (wb_reg[p] != '0);
         err_set   = err_set | (wb_act[p] & bank_miss[wb_warp[p]][p]);
      end
      for (int w = 0; w < WARP_NUM; w++) begin
         bank_we[w] = accept & (alloc_warp == WARP_W'(w));
         for (int p = 0; p < WB_NUM; p++)
            bank_wb_en[w][p] = wb_act[p] & (wb_warp[p] == WARP_W'(w));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (err_set)
         err <= 1'b1;
   end

   for (genvar w = 0; w < WARP_NUM; w++) begin : g_bank
      gelato_scoreboard_bank #(
         .SLOT_NUM (SLOT_NUM),
         .SRC_NUM  (SRC_NUM),
         .WB_NUM   (WB_NUM),
         .CNT_W    (CNT_W)
      ) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .alloc_we  (bank_we[w]),
         .alloc_reg (alloc_reg),
         .wb_en     (bank_wb_en[w]),
         .wb_reg    (wb_reg),
         .chk_rs    (chk_rs),
         .chk_rd    (chk_rd),
         .alloc_dup (bank_dup[w]),
         .wb_miss   (bank_miss[w]),
         .hazard    (bank_haz[w]),
         .full      (bank_full[w]),
         .cnt       (warp_cnt[w])
      );
   end

endmodule

// File: tb/tb_gelato_reg_scoreboard.sv
// tb/tb_gelato_reg_scoreboard.sv - scoreboard bench for gelato_reg_scoreboard against a register-set model
module tb_gelato_reg_scoreboard;

   logic            clk;
   logic            rst_n;
   logic            rdy;
   logic            alloc_valid;
   logic            alloc_ready;
   logic [1:0]      alloc_warp;
   logic [4:0]      alloc_reg;
   logic [1:0]      wb_valid;
   logic [1:0][1:0] wb_warp;
   logic [1:0][4:0] wb_reg;
   logic [1:0]      chk_warp;
   logic [2:0][4:0] chk_rs;
   logic [4:0]      chk_rd;
   logic            hazard;
   logic [3:0]      warp_full;
   logic [3:0][3:0] warp_cnt;
   logic            err;

   gelato_reg_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rdy         (rdy),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_warp  (alloc_warp),
      .alloc_reg   (alloc_reg),
      .wb_valid    (wb_valid),
      .wb_warp     (wb_warp),
      .wb_reg      (wb_reg),
      .chk_warp    (chk_warp),
      .chk_rs      (chk_rs),
      .chk_rd      (chk_rd),
      .hazard      (hazard),
      .warp_full   (warp_full),
      .warp_cnt    (warp_cnt),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ready;
      logic       haz;
      logic       err;
      logic [3:0] full;
      int         cnt [4];
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: the set of dirty registers per warp plus the sticky error bit.
   bit dirty [4][32];
   bit m_err;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int count_dirty(input int w);
      int c = 0;
      for (int r = 1; r < 32; r++) c += dirty[w][r];
      return c;
   endfunction

   task automatic model_clear();
      for (int w = 0; w < 4; w++)
         for (int r = 0; r < 32; r++) dirty[w][r] = 0;
      m_err = 0;
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      rst_n       = 1'b1;
      rdy         = 1'b1;
      alloc_valid = 1'b0;
      alloc_warp  = '0;
      alloc_reg   = '0;
      wb_valid    = '0;
      wb_warp     = '0;
      wb_reg      = '0;
      chk_warp    = '0;
      chk_rs      = '0;
      chk_rd      = '0;
   endtask

   // Expected outputs for this cycle come from the pre-edge model; then the model steps.
   task automatic commit();
      exp_t e;
      bit   nd [4][32];
      bit   dup;
      int   aw, ar, cw;
      aw = alloc_warp; ar = alloc_reg; cw = chk_warp;
      for (int w = 0; w < 4; w++) begin
         e.cnt[w]  = count_dirty(w);
         e.full[w] = (e.cnt[w] == 8);
      end
      dup     = (ar != 0) && dirty[aw][ar];
      e.ready = rdy && (e.cnt[aw] < 8) && !dup;
      e.haz   = (chk_rd != 0) && dirty[cw][chk_rd];
      for (int i = 0; i < 3; i++)
         if (chk_rs[i] != 0 && dirty[cw][chk_rs[i]]) e.haz = 1;
      e.err = m_err;
      exp_q.push_back(e);

      if (rdy) begin
         nd = dirty;
         if (alloc_valid && dup) m_err = 1;
         for (int p = 0; p < 2; p++) begin
            if (wb_valid[p] && wb_reg[p] != 0) begin
               if (!dirty[wb_warp[p]][wb_reg[p]]) m_err = 1;
               else nd[wb_warp[p]][wb_reg[p]] = 0;
            end
         end
         if (alloc_valid && e.ready && ar != 0) nd[aw][ar] = 1;
         dirty = nd;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alloc_ready", alloc_ready, e.ready);
            check("hazard", hazard, e.haz);
            check("err", err, e.err);
            check("warp_full", warp_full, e.full);
            for (int w = 0; w < 4; w++)
               check($sformatf("warp_cnt[%0d]", w), warp_cnt[w], e.cnt[w]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; rdy = 1'b0; alloc_valid = 1'b0; alloc_warp = '0; alloc_reg = '0;
      wb_valid = '0; wb_warp = '0; wb_reg = '0; chk_warp = '0; chk_rs = '0; chk_rd = '0;
      model_clear();
      repeat (3) @(posedge clk);

      begin_cycle(); commit();
      // Warp 1 reg 5 then hazard on it from warp 1 but not warp 0.
      begin_cycle(); alloc_valid = 1; alloc_warp = 1; alloc_reg = 5; commit();
      begin_cycle(); chk_warp = 1; chk_rs[0] = 5; commit();
      begin_cycle(); chk_warp = 0; chk_rs[0] = 5; commit();

      // Fill warp 2, then a ninth request is refused until a release lands.
      for (int r = 1; r <= 9; r++) begin
         begin_cycle(); alloc_valid = 1; alloc_warp = 2; alloc_reg = 5'(r); commit();
      end
      begin_cycle(); wb_valid = 2'b01; wb_warp[0] = 2; wb_reg[0] = 3;
      alloc_valid = 1; alloc_warp = 2; alloc_reg = 10; commit();
      begin_cycle(); alloc_valid = 1; alloc_warp = 2; alloc_reg = 10; commit();
      begin_cycle(); chk_warp = 2; chk_rs[1] = 10; chk_rd = 3; commit();

      // Warp 0: alloc reg7 and release reg4 together.
      for (int r = 1; r <= 4; r++) begin
         if (r == 3) continue;
         begin_cycle(); alloc_valid = 1; alloc_warp = 0; alloc_reg = (r == 1) ? 5'd4 : 5'(r - 1); commit();
      end
      begin_cycle(); alloc_valid = 1; alloc_warp = 0; alloc_reg = 7;
      wb_valid = 2'b10; wb_warp[1] = 0; wb_reg[1] = 4; commit();
      begin_cycle(); chk_warp = 0; chk_rs[2] = 7; commit();
      begin_cycle(); chk_warp = 0; chk_rd = 4; commit();

      // Warp 1: both ports release two regs together, hazard seen only before the edge.
      begin_cycle(); alloc_valid = 1; alloc_warp = 1; alloc_reg = 6; commit();
      begin_cycle(); wb_valid = 2'b11; wb_warp[0] = 1; wb_reg[0] = 5;
      wb_warp[1] = 1; wb_reg[1] = 6; chk_warp = 1; chk_rd = 6; commit();
      begin_cycle(); chk_warp = 1; chk_rd = 6; commit();

      // Same warp/reg on both ports and alloc of a reg being released.
      begin_cycle(); alloc_valid = 1; alloc_warp = 3; alloc_reg = 9; commit();
      begin_cycle(); alloc_valid = 1; alloc_warp = 3; alloc_reg = 9;
      wb_valid = 2'b11; wb_warp[0] = 3; wb_reg[0] = 9; wb_warp[1] = 3; wb_reg[1] = 9; commit();
      begin_cycle(); alloc_valid = 1; alloc_warp = 3; alloc_reg = 0; commit();

      // Duplicate alloc and an unmatched release raise the sticky error.
      begin_cycle(); alloc_valid = 1; alloc_warp = 3; alloc_reg = 9; commit();
      begin_cycle(); alloc_valid = 1; alloc_warp = 3; alloc_reg = 9; commit();
      begin_cycle(); wb_valid = 2'b01; wb_warp[0] = 3; wb_reg[0] = 12; commit();
      begin_cycle(); commit();

      // Frozen when rdy is low.
      begin_cycle(); rdy = 0; alloc_valid = 1; alloc_warp = 1; alloc_reg = 11;
      wb_valid = 2'b11; wb_warp[0] = 3; wb_reg[0] = 9; wb_warp[1] = 2; wb_reg[1] = 1; commit();
      begin_cycle(); commit();

      // Asynchronous reset between edges.
      #3 rst_n = 1'b0;
      #1;
      for (int w = 0; w < 4; w++) check($sformatf("async_rst_cnt[%0d]", w), warp_cnt[w], 0);
      check("async_rst_full", warp_full, 0);
      check("async_rst_err", err, 0);
      model_clear();
      begin_cycle(); commit();

      // Randomized traffic with a small register range to force collisions and fills.
      for (int n = 0; n < 600; n++) begin
         begin_cycle();
         rdy         = ($urandom_range(0, 9) != 0);
         alloc_valid = $urandom_range(0, 3) != 0;
         alloc_warp  = 2'($urandom_range(0, 3));
         alloc_reg   = 5'($urandom_range(0, 11));
         wb_valid    = 2'($urandom_range(0, 3) & (($urandom_range(0, 2) == 0) ? 3 : 0));
         for (int p = 0; p < 2; p++) begin
            wb_warp[p] = 2'($urandom_range(0, 3));
            wb_reg[p]  = 5'($urandom_range(0, 11));
         end
         chk_warp = 2'($urandom_range(0, 3));
         for (int i = 0; i < 3; i++) chk_rs[i] = 5'($urandom_range(0, 11));
         chk_rd = 5'($urandom_range(0, 11));
         commit();
      end

      begin_cycle(); commit();
      repeat (2) @(negedge clk);
      #3;
      check("queue_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
